vga_sync: RTL and testbench

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync.sv | 106 ++++++++++
 tb/tb_vga_sync.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// VGA timing generator: 4:1 pixel-enable divider, x/y raster counters and registered syncs.
// Define VGA_SYNC_FRAME_TICK_EN to add the registered frame_tick output.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
`ifdef VGA_SYNC_FRAME_TICK_EN
    output logic       frame_tick,
`endif
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam logic [9:0] H_DISP     = 10'(H_DISPLAY);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_DISP     = 10'(V_DISPLAY);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);

    logic [1:0] div_q;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic       wrap_frame;

    assign p_tick = (div_q == 2'd3);

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        wrap_frame = 1'b0;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                if (y_q == V_LAST) begin
                    y_d        = 10'd0;
                    wrap_frame = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Syncs are decoded from the next position so they register alongside x/y.
        hsync_d    = !((x_d >= H_SYNC_BEG) && (x_d <= H_SYNC_END));
        vsync_d    = !((y_d >= V_SYNC_BEG) && (y_d <= V_SYNC_END));
        video_on_d = (x_d < H_DISP) && (y_d < V_DISP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= 2'd0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else begin
            div_q      <= div_q + 2'd1;
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

`ifdef VGA_SYNC_FRAME_TICK_EN
    logic frame_tick_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= wrap_frame;
        end
    end

    assign frame_tick = frame_tick_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_frame;
`endif

    assign x        = x_q;
    assign y        = y_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync using shrunken timing so whole frames fit in a short run.
module tb_vga_sync;
  localparam int HD = 16, HF = 4, HS = 6, HB = 4;
  localparam int VD = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hsync, vsync, video_on, p_tick, ft_obs;
  logic [9:0] x, y;

  always #5 clk = ~clk;

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_tick;
  assign ft_obs = frame_tick;
  vga_sync #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
             .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .p_tick(p_tick), .frame_tick(frame_tick), .x(x), .y(y));
`else
  assign ft_obs = 1'b0;
  vga_sync #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
             .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .p_tick(p_tick), .x(x), .y(y));
`endif

  wire [24:0] obs = {ft_obs, p_tick, video_on, vsync, hsync, y, x};

  int checks = 0;
  int errors = 0;
  int k = 0;  // clock edges since reset release
  logic [24:0] exp_q[$];
  logic [24:0] exp_v;

  // Reference: position is simply (edges / 4) pixels into the raster.
  function automatic logic [24:0] model(input int kk);
    int pix, xx, yy;
    logic pt, hs, vs, von, ft;
    pix = kk / 4;
    xx  = pix % HT;
    yy  = (pix / HT) % VT;
    pt  = (kk % 4) == 3;
    hs  = !(xx >= HD + HF && xx < HD + HF + HS);
    vs  = !(yy >= VD + VF && yy < VD + VF + VS);
    von = (xx < HD) && (yy < VD);
`ifdef VGA_SYNC_FRAME_TICK_EN
    ft  = (kk > 0) && (kk % FRAME_CLK == 0);
`else
    ft  = 1'b0;
`endif
    return {ft, pt, von, vs, hs, 10'(yy), 10'(xx)};
  endfunction

  task automatic tick(input logic rst_n);
    reset = rst_n;
    @(posedge clk);
    #1;
    if (!rst_n) k = 0;
    else k++;
    exp_q.push_back(model(k));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_state: got %h expected %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_first_line();
    int hs_low, vo_low;
    hs_low = 0;
    vo_low = 0;
    for (int i = 0; i < HT * 4; i++) begin
      tick(1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL first_line k=%0d: got %h expected %h", k, obs, exp_v);
      end
      if (!hsync) hs_low++;
      if (!video_on) vo_low++;
    end
    checks++;
    if (hs_low !== HS * 4) begin
      errors++;
      $display("FAIL hsync_width: got %0d clk expected %0d", hs_low, HS * 4);
    end
    checks++;
    if (vo_low !== (HT - HD) * 4) begin
      errors++;
      $display("FAIL blank_width: got %0d clk expected %0d", vo_low, (HT - HD) * 4);
    end
    checks++;
    if (x !== 10'd0 || y !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", x, y);
    end
  endtask

  task automatic test_full_frame();
    int vs_low, refresh, ft_n;
    int ft_k[$];
    vs_low = 0;
    refresh = 0;
    ft_n = 0;
    tick(1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 2 * FRAME_CLK + 4; i++) begin
      tick(1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL frame k=%0d: got %h expected %h", k, obs, exp_v);
      end
      if (k <= FRAME_CLK) begin
        if (!vsync) vs_low++;
        if (y == 10'(VD + 1) && x == 10'd0) refresh++;
      end
      if (ft_obs === 1'b1) ft_k.push_back(k);
    end
    checks++;
    if (vs_low !== VS * HT * 4) begin
      errors++;
      $display("FAIL vsync_width: got %0d clk expected %0d", vs_low, VS * HT * 4);
    end
    checks++;
    if (refresh !== 4) begin
      errors++;
      $display("FAIL refresh_tick: got %0d clk expected 4", refresh);
    end
`ifdef VGA_SYNC_FRAME_TICK_EN
    ft_n = ft_k.size();
    checks++;
    if (ft_n !== 2) begin
      errors++;
      $display("FAIL frame_tick_count: got %0d expected 2", ft_n);
    end else begin
      checks++;
      if (ft_k[1] - ft_k[0] !== FRAME_CLK) begin
        errors++;
        $display("FAIL frame_tick_gap: got %0d expected %0d", ft_k[1] - ft_k[0], FRAME_CLK);
      end
    end
`else
    ft_n = ft_k.size();
    checks++;
    if (ft_n !== 0) begin
      errors++;
      $display("FAIL frame_tick_absent: got %0d expected 0", ft_n);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int run, hold;
    for (int n = 0; n < 5; n++) begin
      run  = $urandom_range(FRAME_CLK - 1, 50);
      hold = $urandom_range(3, 1);
      for (int i = 0; i < run; i++) begin
        tick(1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL pre_reset k=%0d: got %h expected %h", k, obs, exp_v);
        end
      end
      for (int i = 0; i < hold; i++) begin
        tick(1'b0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL mid_reset: got %h expected %h", obs, exp_v);
        end
      end
      for (int i = 0; i < 40; i++) begin
        tick(1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL post_reset k=%0d: got %h expected %h", k, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_full_frame();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
